// File: rtl/clock_divider_programable.sv
// Multi-channel runtime-programmable clock divider. Each channel divides clk_in by a
// loadable divisor in toggle (50% duty) or pulse (one-cycle tick) mode.
module clock_divider_programable #(
   parameter int N_CH        = 2,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic                      clk_in,
   input  logic                      reset,
   input  logic [N_CH-1:0]           enable,
   input  logic [N_CH-1:0]           div_load,
   input  logic [N_CH*DIV_WIDTH-1:0] div_value,
   input  logic [N_CH-1:0]           mode_in,
   output logic [N_CH-1:0]           clk_out,
   output logic [N_CH-1:0]           tick,
   output logic [N_CH-1:0]           pending
);

   localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [DIV_WIDTH-1:0] counter;
      logic [DIV_WIDTH-1:0] div_reg;
      logic [DIV_WIDTH-1:0] pend_div;
      logic [DIV_WIDTH-1:0] load_val;
      logic                 mode_reg;
      logic                 pend_mode;
      logic                 pend_flag;
      logic                 clk_q;
      logic                 tick_q;
      logic                 tc;
      logic                 apply;

      assign load_val = div_value[g*DIV_WIDTH +: DIV_WIDTH];
      assign tc       = enable[g] && (counter == div_reg - ONE);
      assign apply    = tc && pend_flag;

      always_ff @(posedge clk_in or posedge reset) begin
         if (reset) begin
            counter   <= '0;
            div_reg   <= DEF_DIV;
            mode_reg  <= 1'b0;
            pend_div  <= DEF_DIV;
            pend_mode <= 1'b0;
            pend_flag <= 1'b0;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
         end else begin
            tick_q <= tc;
            if (tc) begin
               counter <= '0;
               // A mode switch restarts clk_out low so no runt pulse leaks across the change.
               if (apply && (pend_mode != mode_reg)) clk_q <= 1'b0;
               else if (mode_reg)                    clk_q <= 1'b1;
               else                                  clk_q <= ~clk_q;
            end else begin
               if (enable[g]) counter <= counter + ONE;
               if (mode_reg)  clk_q   <= 1'b0;
            end
            if (apply) begin
               div_reg   <= pend_div;
               mode_reg  <= pend_mode;
               pend_flag <= 1'b0;
            end
            // A load on an apply edge wins: it becomes the next pending configuration.
            if (div_load[g]) begin
               pend_div  <= (load_val == '0) ? ONE : load_val;
               pend_mode <= mode_in[g];
               pend_flag <= 1'b1;
            end
         end
      end

      assign clk_out[g] = clk_q;
      assign tick[g]    = tick_q;
      assign pending[g] = pend_flag;
   end

endmodule

// File: tb/tb_clock_divider_programable.sv
// Bench for clock_divider_programable: vector table, corner sequences and random
// stimulus checked against a countdown-based reference model.
module tb_clock_divider_programable;

   localparam int N = 2;
   localparam int W = 16;
   localparam int DEF = 10;

   logic           clk_in = 1'b0;
   logic           reset  = 1'b1;
   logic [N-1:0]   enable = '0;
   logic [N-1:0]   div_load = '0;
   logic [N*W-1:0] div_value = '0;
   logic [N-1:0]   mode_in = '0;
   logic [N-1:0]   clk_out, tick, pending;

   int total = 0;
   int bad   = 0;

   clock_divider_programable #(.N_CH(N), .DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
      .clk_in(clk_in), .reset(reset), .enable(enable), .div_load(div_load),
      .div_value(div_value), .mode_in(mode_in), .clk_out(clk_out), .tick(tick),
      .pending(pending)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: m_left counts enabled cycles still to go until the next terminal count.
   int m_left[N], m_div[N], m_mode[N], m_pdiv[N], m_pmode[N], m_pflag[N], m_clk[N], m_tick[N];

   function automatic void model_reset();
      for (int c = 0; c < N; c++) begin
         m_left[c] = DEF; m_div[c] = DEF; m_mode[c] = 0; m_pdiv[c] = DEF;
         m_pmode[c] = 0; m_pflag[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
   endfunction

   function automatic void model_step(logic [N-1:0] en, logic [N-1:0] ld,
                                      logic [N*W-1:0] val, logic [N-1:0] md);
      for (int c = 0; c < N; c++) begin
         int v;
         if (en[c] && m_left[c] == 1) begin
            m_tick[c] = 1;
            if (m_pflag[c] && m_pmode[c] != m_mode[c]) m_clk[c] = 0;
            else if (m_mode[c] == 1)                   m_clk[c] = 1;
            else                                       m_clk[c] = 1 - m_clk[c];
            if (m_pflag[c]) begin
               m_div[c] = m_pdiv[c]; m_mode[c] = m_pmode[c]; m_pflag[c] = 0;
            end
            m_left[c] = m_div[c];
         end else begin
            m_tick[c] = 0;
            if (en[c]) m_left[c] = m_left[c] - 1;
            if (m_mode[c] == 1) m_clk[c] = 0;
         end
         if (ld[c]) begin
            v = int'(val[c*W +: W]);
            m_pdiv[c] = (v == 0) ? 1 : v;
            m_pmode[c] = int'(md[c]);
            m_pflag[c] = 1;
         end
      end
   endfunction

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void chk_model();
      for (int c = 0; c < N; c++) begin
         chk($sformatf("clk_out[%0d]", c), int'(clk_out[c]), m_clk[c]);
         chk($sformatf("tick[%0d]", c),    int'(tick[c]),    m_tick[c]);
         chk($sformatf("pending[%0d]", c), int'(pending[c]), m_pflag[c]);
      end
   endfunction

   task automatic drive_cycle(input logic [N-1:0] en, input logic [N-1:0] ld,
                              input logic [N*W-1:0] val, input logic [N-1:0] md);
      @(negedge clk_in);
      enable = en; div_load = ld; div_value = val; mode_in = md;
      @(posedge clk_in);
      model_step(en, ld, val, md);
      #1;
      chk_model();
   endtask

   // Reset is raised between clock edges so outputs must clear without a clock.
   task automatic do_reset();
      @(negedge clk_in);
      enable = '0; div_load = '0;
      #2 reset = 1'b1;
      #1;
      chk("reset clk_out", int'(clk_out), 0);
      chk("reset tick",    int'(tick),    0);
      chk("reset pending", int'(pending), 0);
      model_reset();
      @(negedge clk_in);
      reset = 1'b0;
   endtask

   typedef struct {
      int   n;
      logic en, ld;
      int   val;
      logic md;
      logic e_clk, e_tick, e_pend;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int gap, seen, cyc;
      logic [N-1:0] en, ld, md;
      logic [N*W-1:0] val;

      tbl[0]  = '{1, 1, 1, 2, 0, 0, 0, 1};
      tbl[1]  = '{8, 1, 0, 0, 0, 0, 0, 1};
      tbl[2]  = '{1, 1, 0, 0, 0, 1, 1, 0};
      tbl[3]  = '{1, 1, 0, 0, 0, 1, 0, 0};
      tbl[4]  = '{1, 1, 0, 0, 0, 0, 1, 0};
      tbl[5]  = '{1, 1, 1, 1, 1, 0, 0, 1};
      tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 0};
      tbl[7]  = '{3, 1, 0, 0, 0, 1, 1, 0};
      tbl[8]  = '{2, 0, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{1, 1, 1, 0, 0, 1, 1, 1};
      tbl[10] = '{1, 1, 0, 0, 0, 0, 1, 0};
      tbl[11] = '{1, 1, 0, 0, 0, 1, 1, 0};
      tbl[12] = '{1, 1, 0, 0, 0, 0, 1, 0};

      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      chk("initial clk_out", int'(clk_out), 0);
      chk("initial tick",    int'(tick),    0);
      chk("initial pending", int'(pending), 0);
      do_reset();

      // Channel 0 vector table; channel 1 held disabled.
      for (int i = 0; i < 13; i++) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            drive_cycle({1'b0, tbl[i].en}, {1'b0, tbl[i].ld},
                        {W'(0), W'(tbl[i].val)}, {1'b0, tbl[i].md});
            chk($sformatf("tbl%0d clk_out", i), int'(clk_out[0]), int'(tbl[i].e_clk));
            chk($sformatf("tbl%0d tick", i),    int'(tick[0]),    int'(tbl[i].e_tick));
            chk($sformatf("tbl%0d pending", i), int'(pending[0]), int'(tbl[i].e_pend));
         end
      end

      // Default divisor: tick spacing of DEF cycles.
      do_reset();
      gap = 0; seen = 0; cyc = 0;
      while (seen < 2 && cyc < 60) begin
         drive_cycle(2'b11, 2'b00, '0, 2'b00);
         cyc++;
         if (seen == 1) gap++;
         if (tick[0]) seen++;
      end
      chk("default tick seen", seen, 2);
      chk("default tick gap", gap, DEF);

      // Pulse div=5 with a 7-cycle enable drop mid-count.
      drive_cycle(2'b11, 2'b01, {W'(0), W'(5)}, 2'b01);
      repeat (14) drive_cycle(2'b11, 2'b00, '0, 2'b00);
      repeat (7) begin
         drive_cycle(2'b10, 2'b00, '0, 2'b00);
         chk("frozen tick", int'(tick[0]), 0);
      end
      repeat (12) drive_cycle(2'b11, 2'b00, '0, 2'b00);

      // Two loads before the apply point: only the later one takes effect.
      do_reset();
      drive_cycle(2'b11, 2'b01, {W'(0), W'(4)}, 2'b00);
      drive_cycle(2'b11, 2'b01, {W'(0), W'(6)}, 2'b00);
      repeat (40) drive_cycle(2'b11, 2'b00, '0, 2'b00);
      chk("two loads div", m_div[0], 6);

      // Channel 1 div=0 pulse: held high once applied.
      drive_cycle(2'b11, 2'b10, {W'(0), W'(0)}, 2'b10);
      repeat (15) drive_cycle(2'b11, 2'b00, '0, 2'b00);
      chk("div0 ch1 clk_out", int'(clk_out[1]), 1);
      chk("div0 ch1 tick",    int'(tick[1]),    1);

      // Reset mid-count while a load is pending.
      drive_cycle(2'b11, 2'b11, {W'(3), W'(7)}, 2'b01);
      do_reset();
      repeat (12) drive_cycle(2'b11, 2'b00, '0, 2'b00);

      // Randomized stimulus.
      for (int i = 0; i < 2500; i++) begin
         if (i % 800 == 799) do_reset();
         for (int c = 0; c < N; c++) begin
            en[c] = ($urandom_range(0, 7) != 0);
            ld[c] = ($urandom_range(0, 11) == 0);
            md[c] = 1'($urandom_range(0, 1));
            val[c*W +: W] = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 20))
                                                        : W'($urandom_range(0, 6));
         end
         drive_cycle(en, ld, val, md);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
